// File: rtl/wb_host_sequencer.sv
// Wishbone classic single-transfer initiator: accepts one read/write command over a
// valid/ready port, runs one bus cycle, and returns read data or a timeout error.
//
//   state | meaning
//   IDLE  | ready for a command; cmd_ready_o high
//   BUS   | cyc/stb asserted, waiting for ack or timeout
//   RESP  | response valid, waiting for rsp_ready_i
module wb_host_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TOUT_W  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [7:0]  err_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [TOUT_W-1:0] tout_cnt;

  assign cmd_ready_o = (state == IDLE);
  // stb is a copy of the registered cyc, so the two can never diverge
  assign wbm_stb_o   = wbm_cyc_o;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      tout_cnt    <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_cyc_o <= 1'b1;
            tout_cnt  <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // ack has priority over a timeout landing in the same cycle
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            state       <= RESP;
          end else if (tout_cnt == TOUT_LAST) begin
            wbm_cyc_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= 32'd0;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            state       <= RESP;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          wbm_cyc_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_sequencer.sv
// Directed bench for wb_host_sequencer: a vector table of single transfers plus
// hand-written sequences for latency, response back-pressure and mid-cycle reset.
module tb_wb_host_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wb_host_sequencer #(.TIMEOUT(16), .TOUT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;   // BUS cycle index (1-based) on which the slave acks; 0 = never
    logic [31:0] rd;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_cyc;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int ncyc;
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    chk({name, " ready_before"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_adr = 32'hFFFF_FFFF; cmd_dat = 32'h0; cmd_we = ~v.we; cmd_sel = 4'h0;
    chk({name, " stb"}, 32'(stb), 32'd1);
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!cyc) break;
      ncyc++;
      ack   = (ncyc == v.ack_at);
      dat_i = ack ? v.rd : 32'hBAD0_0000 + 32'(ncyc);
      tick();
    end
    ack = 1'b0;
    chk({name, " cyc_cycles"}, 32'(ncyc), 32'(v.exp_cyc));
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({name, " rsp_dat"}, rsp_dat, v.exp_dat);
    chk({name, " err_cnt"}, 32'(err_cnt), 32'(v.exp_cnt));
    chk({name, " adr_kept"}, adr, v.adr);
    chk({name, " dat_kept"}, dat_o, v.dat);
    chk({name, " we_sel_kept"}, {27'd0, we, sel}, {27'd0, v.we, v.sel});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, " rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
    chk({name, " ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2,  32'hFFFF_FFFF, 1'b0, 32'h0,         2,  8'd0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1,  32'h1234_5678, 1'b0, 32'h1234_5678, 1,  8'd0};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0,  32'h0,         1'b1, 32'h0,         16, 8'd1};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3, 16, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 16, 8'd1};
    vecs[4] = '{1'b1, 32'h3000_0010, 32'h0102_0304, 4'h3, 5,  32'h7777_7777, 1'b0, 32'h0,         5,  8'd1};
    vecs[5] = '{1'b1, 32'h3000_0014, 32'hCAFE_F00D, 4'hC, 0,  32'h0,         1'b1, 32'h0,         16, 8'd2};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
    #12;
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_outs", {27'd0, cyc, stb, we, rsp_valid, rsp_err}, 32'd0);
    chk("reset_vals", adr | dat_o | rsp_dat | 32'(sel) | 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // minimum latency with rsp_ready tied high
    rsp_ready = 1'b1;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("lat_t1_cyc", 32'(cyc), 32'd1);
    chk("lat_t1_ready", 32'(cmd_ready), 32'd0);
    ack = 1'b1; dat_i = 32'h1234_5678;
    tick();
    ack = 1'b0;
    chk("lat_t2_cyc", 32'(cyc), 32'd0);
    chk("lat_t2_valid", 32'(rsp_valid), 32'd1);
    chk("lat_t2_dat", rsp_dat, 32'h1234_5678);
    chk("lat_t2_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("lat_t3_ready", 32'(cmd_ready), 32'd1);
    chk("lat_t3_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // response back-pressure with stray acks and a pending command
    cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1; dat_i = 32'h1111_2222;
    tick();
    cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'h1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ack = i[0]; dat_i = 32'h9999_0000 + 32'(i);
      tick();
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_dat", i), rsp_dat, 32'h1111_2222);
      chk($sformatf("bp%0d_ready_cyc", i), {30'd0, cmd_ready, cyc}, 32'd0);
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_no_accept", {30'd0, cmd_ready, cyc}, 32'd2);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_cyc", 32'(cyc), 32'd1);
    chk("bp_next_adr", adr, 32'h3000_0040);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_next_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    chk("bp_next_dat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // asynchronous reset in the middle of a bus cycle
    cmd_we = 1'b0; cmd_adr = 32'h3000_0080; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_pre_cyc", 32'(cyc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("rst_async_ready", 32'(cmd_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; dat_i = 32'hDEAD_0000;
      tick();
    end
    ack = 1'b0;
    chk("rst_no_rsp", {30'd0, rsp_valid, cyc}, 32'd0);
    run_txn('{1'b0, 32'h3000_0100, 32'h0, 4'hF, 3, 32'hFEED_0001, 1'b0, 32'hFEED_0001, 3, 8'd0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
